// File: rtl/abc_vec_pkg.sv
// Shared types for the ABC vector driver: run states, table entry layout
// and the deepest response latency the compare pipeline supports.
package abc_vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic exp;
  } vec_t;

  localparam int MAX_RESP_LAT = 3;

  function automatic vec_t make_vec(input logic [2:0] abc, input logic exp_bit);
    vec_t v;
    v.a   = abc[2];
    v.b   = abc[1];
    v.c   = abc[0];
    v.exp = exp_bit;
    return v;
  endfunction

endpackage

// File: rtl/abc_resp_pipe.sv
// Delay line carrying (valid, idx, exp) RESP_LAT cycles so each entry meets
// the O it expects; RESP_LAT=0 degenerates to a straight wire.
module abc_resp_pipe #(
  parameter int RESP_LAT = 1,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_exp,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_exp
);

  if (RESP_LAT == 0) begin : g_pass
    logic unused_s;
    assign unused_s  = ^{clk, reset, flush};
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
    assign out_exp   = in_exp;
  end else begin : g_dly
    logic [RESP_LAT-1:0] vld_r;
    logic [RESP_LAT-1:0] exp_r;
    logic [IDX_W-1:0]    idx_r [RESP_LAT];

    // Shift one stage per clock; a flush drops every pending compare.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_r <= '0;
        exp_r <= '0;
        for (int i = 0; i < RESP_LAT; i++) begin
          idx_r[i] <= '0;
        end
      end else begin
        vld_r[0] <= in_valid & ~flush;
        exp_r[0] <= in_exp;
        idx_r[0] <= in_idx;
        for (int i = 1; i < RESP_LAT; i++) begin
          vld_r[i] <= vld_r[i-1] & ~flush;
          exp_r[i] <= exp_r[i-1];
          idx_r[i] <= idx_r[i-1];
        end
      end
    end

    assign out_valid = vld_r[RESP_LAT-1];
    assign out_idx   = idx_r[RESP_LAT-1];
    assign out_exp   = exp_r[RESP_LAT-1];
  end

endmodule

// File: rtl/abc_vector_driver.sv
// Self-test vector driver: replays a stored (A,B,C,exp) table into the
// circuit under test and scores O. Define ABC_STOP_ON_FAIL_EN to end a run
// at its first mismatch.
module abc_vector_driver
  import abc_vec_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int RESP_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [2:0]       wr_vec,
  input  logic             wr_exp,
  input  logic [IDX_W:0]   len,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             O,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   err_cnt,
  output logic [IDX_W-1:0] first_fail,
  output logic             any_fail
);

  localparam logic [IDX_W:0]   DEPTH_L    = (IDX_W+1)'(DEPTH);
  localparam int               DRN_W      = $clog2(MAX_RESP_LAT + 1);
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

  vec_t             tbl_r [DEPTH];
  state_e           state_r;
  logic [IDX_W:0]   len_r;
  logic [IDX_W:0]   idx_r;
  logic [DRN_W-1:0] drain_r;
  logic             drv_valid_r;
  logic [IDX_W-1:0] drv_idx_r;
  logic             drv_exp_r;
  logic             cmp_valid_s;
  logic [IDX_W-1:0] cmp_idx_s;
  logic             cmp_exp_s;
  logic             mismatch_s;
  logic             stop_s;
  vec_t             cur_s;

  // Table storage has no reset; writes are blocked while a run owns it.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      tbl_r[wr_addr] <= make_vec(wr_vec, wr_exp);
    end
  end

  assign cur_s      = tbl_r[idx_r[IDX_W-1:0]];
  assign mismatch_s = cmp_valid_s && (O != cmp_exp_s);

`ifdef ABC_STOP_ON_FAIL_EN
  assign stop_s = mismatch_s;
`else
  assign stop_s = 1'b0;
`endif

  abc_resp_pipe #(
    .RESP_LAT (RESP_LAT),
    .IDX_W    (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (stop_s),
    .in_valid  (drv_valid_r),
    .in_idx    (drv_idx_r),
    .in_exp    (drv_exp_r),
    .out_valid (cmp_valid_s),
    .out_idx   (cmp_idx_s),
    .out_exp   (cmp_exp_s)
  );

  // Run sequencer: drives one vector per cycle, drains the compare pipe, scores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      len_r       <= '0;
      idx_r       <= '0;
      drain_r     <= '0;
      A           <= 1'b0;
      B           <= 1'b0;
      C           <= 1'b0;
      drv_valid_r <= 1'b0;
      drv_idx_r   <= '0;
      drv_exp_r   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cnt     <= '0;
      first_fail  <= '0;
      any_fail    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            len_r      <= len;
            err_cnt    <= '0;
            first_fail <= '0;
            any_fail   <= 1'b0;
            if (len == '0 || len > DEPTH_L) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r     <= RUN;
              busy        <= 1'b1;
              done        <= 1'b0;
              A           <= tbl_r[0].a;
              B           <= tbl_r[0].b;
              C           <= tbl_r[0].c;
              drv_valid_r <= 1'b1;
              drv_idx_r   <= '0;
              drv_exp_r   <= tbl_r[0].exp;
              idx_r       <= (IDX_W+1)'(1);
            end
          end
        end
        RUN: begin
          if (stop_s) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            drv_valid_r <= 1'b0;
          end else if (idx_r < len_r) begin
            A           <= cur_s.a;
            B           <= cur_s.b;
            C           <= cur_s.c;
            drv_valid_r <= 1'b1;
            drv_idx_r   <= idx_r[IDX_W-1:0];
            drv_exp_r   <= cur_s.exp;
            idx_r       <= idx_r + 1'b1;
          end else begin
            // Last vector already on the pins: A,B,C hold while the pipe empties.
            drv_valid_r <= 1'b0;
            if (RESP_LAT == 0) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= DRAIN;
              drain_r <= DRAIN_INIT;
            end
          end
        end
        DRAIN: begin
          if (stop_s || drain_r == '0) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_r <= drain_r - 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase

      if (mismatch_s) begin
        if (err_cnt != DEPTH_L) begin
          err_cnt <= err_cnt + 1'b1;
        end
        if (!any_fail) begin
          any_fail   <= 1'b1;
          first_fail <= cmp_idx_s;
        end
      end
    end
  end

endmodule
